// File: rtl/spi_mitm_controller.sv
// spi_mitm_controller
//   Bus-level SPI man-in-the-middle controller. Watches the slave selects,
//   runs the transaction FSM, shifts the real MISO/MOSI bits into
//   real_*_data and can substitute either line with a fake word supplied by
//   the MITM logic through the eval/eval_done handshake.
// Ports
//   sys_clk, rst_n                 system clock, async active-low reset
//   miso_in/mosi_in/sclk_in/ss_in  bus inputs from the pins
//   miso_out/mosi_out/sclk_out     bus outputs (passthrough unless substituted)
//   ss_out                         combinational copy of ss_in
//   mitm_start, active_ch          transaction start pulse, selected channel
//   eval, eval_done, mitm_done     segment handshake with the MITM logic
//   data_size, fake_*_data/select  parameters of the next segment
//   real_miso_data/real_mosi_data  last captured (or partial) segment
//   aborted, timed_out             one-cycle status pulses
module spi_mitm_controller #(
    parameter int MAX_DATA_SIZE  = 16,
    parameter int NUM_SS         = 2,
    parameter int SS_ACTIVE_LOW  = 1,
    parameter int CPOL           = 0,
    parameter int CPHA           = 0,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int DSW = $clog2(MAX_DATA_SIZE + 1),
    localparam int CHW = ($clog2(NUM_SS) > 0) ? $clog2(NUM_SS) : 1
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     miso_in,
    input  logic                     mosi_in,
    input  logic                     sclk_in,
    input  logic [NUM_SS-1:0]        ss_in,
    output logic                     miso_out,
    output logic                     mosi_out,
    output logic                     sclk_out,
    output logic [NUM_SS-1:0]        ss_out,
    output logic                     mitm_start,
    output logic [CHW-1:0]           active_ch,
    output logic                     eval,
    output logic [MAX_DATA_SIZE-1:0] real_miso_data,
    output logic [MAX_DATA_SIZE-1:0] real_mosi_data,
    input  logic [DSW-1:0]           data_size,
    input  logic [MAX_DATA_SIZE-1:0] fake_miso_data,
    input  logic [MAX_DATA_SIZE-1:0] fake_mosi_data,
    input  logic                     fake_miso_select,
    input  logic                     fake_mosi_select,
    input  logic                     eval_done,
    input  logic                     mitm_done,
    output logic                     aborted,
    output logic                     timed_out
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [NUM_SS-1:0] SS_IDLE = (SS_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic SCLK_IDLE = (CPOL != 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVAL_REQ,
        ST_EVAL_WAIT,
        ST_COMM,
        ST_DONE
    } state_t;

    state_t state;

    logic              sclk_s1, sclk_s2, sclk_s3;
    logic [NUM_SS-1:0] ss_s1, ss_s2, ss_s3;
    logic              miso_s1, miso_s2, mosi_s1, mosi_s2;

    // Synchronisers reset to the idle bus levels so no edge is seen after reset.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1 <= SCLK_IDLE;
            sclk_s2 <= SCLK_IDLE;
            sclk_s3 <= SCLK_IDLE;
            ss_s1   <= SS_IDLE;
            ss_s2   <= SS_IDLE;
            ss_s3   <= SS_IDLE;
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= sclk_in;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            ss_s1   <= ss_in;
            ss_s2   <= ss_s1;
            ss_s3   <= ss_s2;
            miso_s1 <= miso_in;
            miso_s2 <= miso_s1;
            mosi_s1 <= mosi_in;
            mosi_s2 <= mosi_s1;
        end
    end

    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, drive_edge;
    logic [NUM_SS-1:0] ss_act, ss_act_d, ss_assert, ss_deassert;
    logic sel_deassert;

    assign sclk_rise    = sclk_s2 & ~sclk_s3;
    assign sclk_fall    = ~sclk_s2 & sclk_s3;
    assign lead_edge    = (CPOL != 0) ? sclk_fall : sclk_rise;
    assign trail_edge   = (CPOL != 0) ? sclk_rise : sclk_fall;
    assign sample_edge  = (CPHA != 0) ? trail_edge : lead_edge;
    assign drive_edge   = (CPHA != 0) ? lead_edge : trail_edge;
    assign ss_act       = (SS_ACTIVE_LOW != 0) ? ~ss_s2 : ss_s2;
    assign ss_act_d     = (SS_ACTIVE_LOW != 0) ? ~ss_s3 : ss_s3;
    assign ss_assert    = ss_act & ~ss_act_d;
    assign ss_deassert  = ~ss_act & ss_act_d;
    assign sel_deassert = ss_deassert[active_ch];

    logic [CHW-1:0] first_ch;
    logic           first_found;

    always_comb begin
        first_ch    = '0;
        first_found = 1'b0;
        for (int unsigned i = 0; i < NUM_SS; i++) begin
            if (ss_assert[i] && !first_found) begin
                first_ch    = CHW'(i);
                first_found = 1'b1;
            end
        end
    end

    logic [DSW-1:0] size_clamped, align_shift;

    assign size_clamped = (data_size > DSW'(MAX_DATA_SIZE)) ? DSW'(MAX_DATA_SIZE) : data_size;
    assign align_shift  = DSW'(MAX_DATA_SIZE) - size_clamped;

    logic [DSW-1:0]           size_q, bit_cnt, adv_left;
    logic                     drv_primed, sel_miso_q, sel_mosi_q;
    logic [MAX_DATA_SIZE-1:0] miso_sh, mosi_sh;
    logic [TW-1:0]            tmo_cnt;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            mitm_start     <= 1'b0;
            eval           <= 1'b0;
            aborted        <= 1'b0;
            timed_out      <= 1'b0;
            active_ch      <= '0;
            real_miso_data <= '0;
            real_mosi_data <= '0;
            size_q         <= '0;
            bit_cnt        <= '0;
            adv_left       <= '0;
            drv_primed     <= 1'b0;
            sel_miso_q     <= 1'b0;
            sel_mosi_q     <= 1'b0;
            miso_sh        <= '0;
            mosi_sh        <= '0;
            tmo_cnt        <= '0;
        end else begin
            mitm_start <= 1'b0;
            eval       <= 1'b0;
            aborted    <= 1'b0;
            timed_out  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|ss_assert) begin
                        active_ch  <= first_ch;
                        mitm_start <= 1'b1;
                        state      <= ST_EVAL_REQ;
                    end
                end
                ST_EVAL_REQ: begin
                    if (sel_deassert) begin
                        aborted <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        eval  <= 1'b1;
                        state <= ST_EVAL_WAIT;
                    end
                end
                ST_EVAL_WAIT: begin
                    if (sel_deassert) begin
                        aborted <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (eval_done) begin
                        if (mitm_done || size_clamped == '0) begin
                            state <= ST_DONE;
                        end else begin
                            size_q         <= size_clamped;
                            sel_miso_q     <= fake_miso_select;
                            sel_mosi_q     <= fake_mosi_select;
                            // Left-align so the segment MSB is always at the top bit.
                            miso_sh        <= fake_miso_data << align_shift;
                            mosi_sh        <= fake_mosi_data << align_shift;
                            adv_left       <= size_clamped - DSW'(1);
                            // CPHA=1: the first drive edge presents the MSB already shown.
                            drv_primed     <= (CPHA == 0);
                            bit_cnt        <= '0;
                            tmo_cnt        <= '0;
                            real_miso_data <= '0;
                            real_mosi_data <= '0;
                            state          <= ST_COMM;
                        end
                    end
                end
                ST_COMM: begin
                    if (sel_deassert) begin
                        aborted <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (bit_cnt == size_q) begin
                        state <= ST_EVAL_REQ;
                    end else begin
                        if (sample_edge) begin
                            real_miso_data <= {real_miso_data[MAX_DATA_SIZE-2:0], miso_s2};
                            real_mosi_data <= {real_mosi_data[MAX_DATA_SIZE-2:0], mosi_s2};
                            bit_cnt        <= bit_cnt + DSW'(1);
                            tmo_cnt        <= '0;
                        end else if (TIMEOUT_CYCLES != 0 && tmo_cnt == TMO_LAST) begin
                            timed_out <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                        if (drive_edge) begin
                            if (!drv_primed) begin
                                drv_primed <= 1'b1;
                            end else if (adv_left != '0) begin
                                miso_sh  <= {miso_sh[MAX_DATA_SIZE-2:0], 1'b0};
                                mosi_sh  <= {mosi_sh[MAX_DATA_SIZE-2:0], 1'b0};
                                adv_left <= adv_left - DSW'(1);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (sel_deassert) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign miso_out = (state == ST_COMM && sel_miso_q) ? miso_sh[MAX_DATA_SIZE-1] : miso_in;
    assign mosi_out = (state == ST_COMM && sel_mosi_q) ? mosi_sh[MAX_DATA_SIZE-1] : mosi_in;
    assign sclk_out = sclk_in;
    assign ss_out   = ss_in;

endmodule

// File: tb/tb_spi_mitm_controller.sv
// Testbench for spi_mitm_controller: instance 0 runs mode 0 with a 50-cycle
// timeout, instance 1 runs mode 3 with the timeout disabled.
module tb_spi_mitm_controller;

    localparam int H = 8;  // SCLK half period in sys_clk cycles

    logic sys_clk = 1'b0;
    logic rst_n;
    always #5 sys_clk = ~sys_clk;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    bit  run = 1'b0;

    logic        sclk_p [2];
    logic        miso_p [2];
    logic        mosi_p [2];
    logic [1:0]  ss_p [2];
    logic [4:0]  data_size_p [2];
    logic [15:0] fake_miso_p [2];
    logic [15:0] fake_mosi_p [2];
    logic        sel_miso_p [2];
    logic        sel_mosi_p [2];
    logic        eval_done_p [2];
    logic        mitm_done_p [2];

    logic        miso_o [2];
    logic        mosi_o [2];
    logic        sclk_o [2];
    logic [1:0]  ss_o [2];
    logic        start_o [2];
    logic [0:0]  active_o [2];
    logic        eval_o [2];
    logic [15:0] real_miso_o [2];
    logic [15:0] real_mosi_o [2];
    logic        aborted_o [2];
    logic        timed_out_o [2];

    int eval_cnt [2];
    int start_cnt [2];
    int abort_cnt [2];
    int tmo_cnt [2];
    int tmo_cyc [2];
    int last_rise [2];
    bit exp_pass_miso [2];
    bit exp_pass_mosi [2];

    spi_mitm_controller #(
        .MAX_DATA_SIZE(16), .NUM_SS(2), .SS_ACTIVE_LOW(1),
        .CPOL(0), .CPHA(0), .TIMEOUT_CYCLES(50)
    ) u_dut0 (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .miso_in(miso_p[0]), .mosi_in(mosi_p[0]), .sclk_in(sclk_p[0]), .ss_in(ss_p[0]),
        .miso_out(miso_o[0]), .mosi_out(mosi_o[0]), .sclk_out(sclk_o[0]), .ss_out(ss_o[0]),
        .mitm_start(start_o[0]), .active_ch(active_o[0]), .eval(eval_o[0]),
        .real_miso_data(real_miso_o[0]), .real_mosi_data(real_mosi_o[0]),
        .data_size(data_size_p[0]),
        .fake_miso_data(fake_miso_p[0]), .fake_mosi_data(fake_mosi_p[0]),
        .fake_miso_select(sel_miso_p[0]), .fake_mosi_select(sel_mosi_p[0]),
        .eval_done(eval_done_p[0]), .mitm_done(mitm_done_p[0]),
        .aborted(aborted_o[0]), .timed_out(timed_out_o[0])
    );

    spi_mitm_controller #(
        .MAX_DATA_SIZE(16), .NUM_SS(2), .SS_ACTIVE_LOW(1),
        .CPOL(1), .CPHA(1), .TIMEOUT_CYCLES(0)
    ) u_dut3 (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .miso_in(miso_p[1]), .mosi_in(mosi_p[1]), .sclk_in(sclk_p[1]), .ss_in(ss_p[1]),
        .miso_out(miso_o[1]), .mosi_out(mosi_o[1]), .sclk_out(sclk_o[1]), .ss_out(ss_o[1]),
        .mitm_start(start_o[1]), .active_ch(active_o[1]), .eval(eval_o[1]),
        .real_miso_data(real_miso_o[1]), .real_mosi_data(real_mosi_o[1]),
        .data_size(data_size_p[1]),
        .fake_miso_data(fake_miso_p[1]), .fake_mosi_data(fake_mosi_p[1]),
        .fake_miso_select(sel_miso_p[1]), .fake_mosi_select(sel_mosi_p[1]),
        .eval_done(eval_done_p[1]), .mitm_done(mitm_done_p[1]),
        .aborted(aborted_o[1]), .timed_out(timed_out_o[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: a segment of n sample edges leaves the last n bits shifted in,
    // MSB first, right-aligned; the segment length never exceeds 16.
    function automatic int clamp_size(input int ds);
        return (ds > 16) ? 16 : ds;
    endfunction

    function automatic logic [31:0] model_real(input logic [31:0] w, input int n);
        logic [31:0] mask;
        mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        return w & mask;
    endfunction

    initial forever begin
        @(posedge sys_clk);
        cyc++;
    end

    // Per-cycle compare: passthrough rules and pulse bookkeeping.
    initial forever begin
        @(negedge sys_clk);
        if (run && rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (eval_o[d])      eval_cnt[d]++;
                if (start_o[d])     start_cnt[d]++;
                if (aborted_o[d])   abort_cnt[d]++;
                if (timed_out_o[d]) begin
                    tmo_cnt[d]++;
                    tmo_cyc[d] = cyc;
                end
                chk("ss_pass", 32'(ss_o[d]), 32'(ss_p[d]));
                chk("sclk_pass", 32'(sclk_o[d]), 32'(sclk_p[d]));
                if (exp_pass_miso[d]) chk("miso_pass", 32'(miso_o[d]), 32'(miso_p[d]));
                if (exp_pass_mosi[d]) chk("mosi_pass", 32'(mosi_o[d]), 32'(mosi_p[d]));
                if (aborted_o[d]) chk("abort_same_cycle_mux", 32'(miso_o[d]), 32'(miso_p[d]));
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // kind: 0 eval, 1 aborted, 2 timed_out
    function automatic int get_cnt(input int d, input int kind);
        case (kind)
            0:       return eval_cnt[d];
            1:       return abort_cnt[d];
            default: return tmo_cnt[d];
        endcase
    endfunction

    task automatic wait_pulse(input int d, input int kind, input int base, input int bound, input string nm);
        for (int i = 0; i < bound; i++) begin
            if (get_cnt(d, kind) > base) break;
            wait_cyc(1);
        end
        chk(nm, 32'(get_cnt(d, kind)), 32'(base + 1));
    endtask

    task automatic xfer(input int d, input int n, input logic [31:0] mosi_w, input logic [31:0] miso_w,
                        output logic [31:0] got_miso, output logic [31:0] got_mosi);
        got_miso = '0;
        got_mosi = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (d == 1) sclk_p[d] = 1'b0;
            mosi_p[d] = mosi_w[i];
            miso_p[d] = miso_w[i];
            wait_cyc(H);
            sclk_p[d] = 1'b1;
            last_rise[d] = cyc;
            got_miso = {got_miso[30:0], miso_o[d]};
            got_mosi = {got_mosi[30:0], mosi_o[d]};
            wait_cyc(H);
            if (d == 0) sclk_p[d] = 1'b0;
        end
    endtask

    task automatic respond(input int d, input int sz, input logic [15:0] fm, input logic [15:0] fo,
                           input logic sm, input logic so, input logic done);
        data_size_p[d] = 5'(sz);
        fake_miso_p[d] = fm;
        fake_mosi_p[d] = fo;
        sel_miso_p[d]  = sm;
        sel_mosi_p[d]  = so;
        mitm_done_p[d] = done;
        if (!done && sz != 0) begin
            exp_pass_miso[d] = !sm;
            exp_pass_mosi[d] = !so;
        end
        eval_done_p[d] = 1'b1;
        wait_cyc(1);
        eval_done_p[d] = 1'b0;
        mitm_done_p[d] = 1'b0;
        wait_cyc(10);
    endtask

    task automatic start_txn(input int d, input int ch, input string nm);
        int s0, e0;
        s0 = start_cnt[d];
        e0 = eval_cnt[d];
        ss_p[d][ch] = 1'b0;
        wait_pulse(d, 0, e0, 40, {nm, "_eval"});
        chk({nm, "_start"}, 32'(start_cnt[d]), 32'(s0 + 1));
        chk({nm, "_active_ch"}, 32'(active_o[d]), 32'(ch));
    endtask

    task automatic end_txn(input int d, input string nm);
        int a0;
        a0 = abort_cnt[d];
        ss_p[d] = 2'b11;
        wait_cyc(10);
        chk({nm, "_no_abort"}, 32'(abort_cnt[d]), 32'(a0));
    endtask

    initial begin
        logic [31:0] gm, go, gm2, go2;
        int e0, a0, t0;

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            sclk_p[d] = (d == 1);
            miso_p[d] = 1'b0;
            mosi_p[d] = 1'b0;
            ss_p[d] = 2'b11;
            data_size_p[d] = '0;
            fake_miso_p[d] = '0;
            fake_mosi_p[d] = '0;
            sel_miso_p[d] = 1'b0;
            sel_mosi_p[d] = 1'b0;
            eval_done_p[d] = 1'b0;
            mitm_done_p[d] = 1'b0;
            eval_cnt[d] = 0;
            start_cnt[d] = 0;
            abort_cnt[d] = 0;
            tmo_cnt[d] = 0;
            tmo_cyc[d] = 0;
            last_rise[d] = 0;
            exp_pass_miso[d] = 1'b1;
            exp_pass_mosi[d] = 1'b1;
        end
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);
        run = 1'b1;

        // Reset state
        for (int d = 0; d < 2; d++) begin
            chk("rst_mitm_start", 32'(start_o[d]), 0);
            chk("rst_eval", 32'(eval_o[d]), 0);
            chk("rst_active_ch", 32'(active_o[d]), 0);
            chk("rst_real_miso", 32'(real_miso_o[d]), 0);
            chk("rst_real_mosi", 32'(real_mosi_o[d]), 0);
            chk("rst_status", 32'({aborted_o[d], timed_out_o[d]}), 0);
        end
        miso_p[0] = 1'b1;
        #1 chk("rst_miso_pass_1", 32'(miso_o[0]), 1);
        miso_p[0] = 1'b0;
        #1 chk("rst_miso_pass_0", 32'(miso_o[0]), 0);
        wait_cyc(2);

        // Mode 0, channel 1: fake MISO 8'hA5, master clocks MOSI 8'h3C
        start_txn(0, 1, "t1");
        respond(0, 8, 16'h00A5, 16'h0000, 1'b1, 1'b0, 1'b0);
        e0 = eval_cnt[0];
        xfer(0, 8, 32'h3C, 32'h0F, gm, go);
        chk("t1_miso_out_bits", gm, 32'hA5);
        chk("t1_mosi_out_bits", go, 32'h3C);
        wait_pulse(0, 0, e0, 40, "t1_next_eval");
        exp_pass_miso[0] = 1'b1;
        chk("t1_real_mosi_lit", 32'(real_mosi_o[0]), 32'h003C);
        chk("t1_real_mosi", 32'(real_mosi_o[0]), model_real(32'h3C, clamp_size(8)));
        chk("t1_real_miso", 32'(real_miso_o[0]), model_real(32'h0F, clamp_size(8)));
        respond(0, 0, '0, '0, 1'b0, 1'b0, 1'b1);
        end_txn(0, "t1");

        // Mode 3, size 16, no substitution
        start_txn(1, 0, "t2");
        respond(1, 16, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        e0 = eval_cnt[1];
        xfer(1, 16, 32'h5A0F, 32'hB3C5, gm, go);
        chk("t2_miso_out_bits", gm, 32'hB3C5);
        chk("t2_mosi_out_bits", go, 32'h5A0F);
        wait_pulse(1, 0, e0, 40, "t2_next_eval");
        chk("t2_real_miso", 32'(real_miso_o[1]), model_real(32'hB3C5, clamp_size(16)));
        chk("t2_real_mosi", 32'(real_mosi_o[1]), model_real(32'h5A0F, clamp_size(16)));
        respond(1, 0, '0, '0, 1'b0, 1'b0, 1'b1);
        end_txn(1, "t2");

        // data_size=20 clamps to 16 sample edges
        start_txn(0, 0, "t3");
        respond(0, 20, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        e0 = eval_cnt[0];
        xfer(0, 15, 32'hC3A5 >> 1, 32'h1E96 >> 1, gm, go);
        wait_cyc(12);
        chk("t3_no_eval_after_15", 32'(eval_cnt[0]), 32'(e0));
        xfer(0, 1, 32'h1, 32'h0, gm2, go2);
        wait_pulse(0, 0, e0, 40, "t3_eval_after_16");
        chk("t3_real_mosi_lit", 32'(real_mosi_o[0]), 32'hC3A5);
        chk("t3_real_miso", 32'(real_miso_o[0]), model_real(32'h1E96, clamp_size(20)));
        respond(0, 0, '0, '0, 1'b0, 1'b0, 1'b1);
        end_txn(0, "t3");
        chk("t3_no_timeouts_yet", 32'(tmo_cnt[0]), 0);

        // Abort after 3 of 8 bits
        start_txn(0, 0, "t4");
        respond(0, 8, 16'h00A5, 16'h0000, 1'b1, 1'b0, 1'b0);
        e0 = eval_cnt[0];
        a0 = abort_cnt[0];
        xfer(0, 3, 32'b110, 32'b011, gm, go);
        chk("t4_miso_out_bits", gm, 32'b101);
        wait_cyc(6);
        miso_p[0] = 1'b1;
        wait_cyc(1);
        chk("t4_fake_bit4_held", 32'(miso_o[0]), 0);
        ss_p[0] = 2'b11;
        wait_pulse(0, 1, a0, 20, "t4_aborted");
        exp_pass_miso[0] = 1'b1;
        chk("t4_real_mosi_partial", 32'(real_mosi_o[0]), model_real(32'b110, 3));
        chk("t4_real_miso_partial", 32'(real_miso_o[0]), 32'h0003);
        wait_cyc(10);
        chk("t4_no_eval_after_abort", 32'(eval_cnt[0]), 32'(e0));

        // Timeout: SCLK stops after 3 bits
        start_txn(0, 1, "t5");
        respond(0, 8, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        e0 = eval_cnt[0];
        t0 = tmo_cnt[0];
        xfer(0, 3, 32'b101, 32'b010, gm, go);
        wait_pulse(0, 2, t0, 100, "t5_timed_out");
        chk("t5_timeout_latency", 32'(tmo_cyc[0] - last_rise[0]), 32'(3 + 50));
        xfer(0, 2, 32'b11, 32'b10, gm, go);
        chk("t5_done_miso_pass", gm, 32'b10);
        chk("t5_real_mosi_kept", 32'(real_mosi_o[0]), 32'h0005);
        chk("t5_no_eval", 32'(eval_cnt[0]), 32'(e0));
        end_txn(0, "t5");

        // mitm_done on the first eval: passthrough, no more evals
        start_txn(0, 1, "t6");
        e0 = eval_cnt[0];
        respond(0, 8, 16'h00FF, 16'h00FF, 1'b1, 1'b1, 1'b1);
        xfer(0, 8, 32'h96, 32'h69, gm, go);
        chk("t6_miso_pass_bits", gm, 32'h69);
        chk("t6_mosi_pass_bits", go, 32'h96);
        wait_cyc(20);
        chk("t6_no_more_eval", 32'(eval_cnt[0]), 32'(e0));
        end_txn(0, "t6");

        // Reset mid-COMM returns the mux to passthrough immediately
        start_txn(0, 0, "t7");
        respond(0, 8, 16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b0);
        miso_p[0] = 1'b0;
        wait_cyc(1);
        chk("t7_fake_active", 32'(miso_o[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_passthrough", 32'(miso_o[0]), 0);
        chk("t7_rst_active_ch", 32'(active_o[0]), 0);
        ss_p[0] = 2'b11;
        exp_pass_miso[0] = 1'b1;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
